// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if
//   Serial line plus packet result bundle of the UART frame receiver.
//   in_bit      : serial line into the receiver (idle high)
//   o_opt/o_len : option and length bytes of the last good packet
//   o_data      : payload, byte k at [k*BYTE_SIZE +: BYTE_SIZE], unused bytes 0
//   o_valid     : one-cycle pulse per complete packet
//   o_err       : one-cycle pulse per rejected packet, cause in o_err_code
//   master = receiver side, slave = line driver / packet consumer side.
interface uart_frame_rx_if #(
  parameter int BYTE_SIZE     = 8,
  parameter int OUT_DATA_SIZE = 32
);
  logic                     in_bit;
  logic [BYTE_SIZE-1:0]     o_opt;
  logic [BYTE_SIZE-1:0]     o_len;
  logic [OUT_DATA_SIZE-1:0] o_data;
  logic                     o_valid;
  logic                     o_err;
  logic [1:0]               o_err_code;

  modport master (input in_bit, output o_opt, o_len, o_data, o_valid, o_err, o_err_code);
  modport slave  (output in_bit, input o_opt, o_len, o_data, o_valid, o_err, o_err_code);
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Oversampled UART receiver (3-sample majority, glitch-rejecting start)
//   feeding a packet assembler: opt, len, then len payload bytes.
//   An inter-byte idle timeout resynchronises the packet layer.
//   Ports:
//     CLK, RST : clock, asynchronous active-high reset
//     bus      : uart_frame_rx_if.master (in_bit in, packet results out)
//   Error codes: 0 timeout, 1 framing, 2 parity, 3 length.
//   Build option: define UART_RX_PARITY_EN to add one parity bit per
//   character (sense from PARITY_ODD); otherwise parity is absent.
module uart_frame_rx #(
  parameter int BYTE_SIZE     = 8,
  parameter int FREQ_COEF     = 16,
  parameter int MAX_MSG_LEN   = 4,
  parameter int OUT_DATA_SIZE = MAX_MSG_LEN * BYTE_SIZE,
  parameter int PARITY_ODD    = 0,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic            CLK,
  input  logic            RST,
  uart_frame_rx_if.master bus
);
  localparam int CW = $clog2(FREQ_COEF);
  localparam int BW = $clog2(BYTE_SIZE + 1);
  localparam int TW = $clog2(TIMEOUT_BITS + 2);
  localparam int IW = $clog2(MAX_MSG_LEN + 1);

  localparam logic [CW-1:0] SMP0  = CW'(FREQ_COEF/2 - 1);
  localparam logic [CW-1:0] SMP1  = CW'(FREQ_COEF/2);
  localparam logic [CW-1:0] SMP2  = CW'(FREQ_COEF/2 + 1);
  localparam logic [CW-1:0] CLAST = CW'(FREQ_COEF - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  localparam logic [1:0] P_OPT  = 2'd0;
  localparam logic [1:0] P_LEN  = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
  localparam logic [1:0] P_DROP = 2'd3;

  // ---------------- input synchronizer and start-edge detect
  logic [1:0] sync_q;
  logic       line_d;
  logic       line, fall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
      line_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], bus.in_bit};
      line_d <= sync_q[1];
    end
  end

  assign line = sync_q[1];
  assign fall = line_d & ~line;

  // ---------------- byte FSM
  logic [2:0]           st;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [1:0]           smp;
  logic [BYTE_SIZE-1:0] shreg;
  logic [TW-1:0]        to_cnt;
  logic                 maj, perr_c, to_fire;
  logic                 bd_vld, bd_ferr, bd_perr;
  logic [BYTE_SIZE-1:0] bd_byte;

  // third sample is the live line value, first two were latched earlier
  assign maj     = (smp[0] & smp[1]) | (smp[0] & line) | (smp[1] & line);
  assign to_fire = (to_cnt == TW'(TIMEOUT_BITS));

`ifdef UART_RX_PARITY_EN
  logic par_q;
  assign perr_c = (^shreg) ^ par_q ^ (PARITY_ODD != 0);
`else
  logic unused_par;
  assign unused_par = (PARITY_ODD != 0);
  assign perr_c     = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st      <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      smp     <= '0;
      shreg   <= '0;
      to_cnt  <= '0;
      bd_vld  <= 1'b0;
      bd_ferr <= 1'b0;
      bd_perr <= 1'b0;
      bd_byte <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      bd_vld <= 1'b0;
      // free-running in IDLE too, so it also paces the idle timeout
      cnt <= (cnt == CLAST) ? '0 : cnt + 1'b1;
      if (cnt == SMP0) smp[0] <= line;
      if (cnt == SMP1) smp[1] <= line;
      case (st)
        S_IDLE: if (fall) begin
          st  <= S_START;
          cnt <= '0;
        end
        S_START: begin
          if (cnt == SMP2 && maj) begin
            st  <= S_IDLE;               // glitch, not a start bit
            cnt <= '0;
          end else if (cnt == CLAST) begin
            st      <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (cnt == SMP2) shreg <= {maj, shreg[BYTE_SIZE-1:1]};
          if (cnt == CLAST) begin
            if (bit_idx == BW'(BYTE_SIZE - 1)) begin
`ifdef UART_RX_PARITY_EN
              st <= S_PARITY;
`else
              st <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == SMP2) par_q <= maj;
          if (cnt == CLAST) st <= S_STOP;
        end
`endif
        S_STOP: if (cnt == SMP2) begin
          // leave half a bit early so a back-to-back start edge is caught
          st      <= S_IDLE;
          cnt     <= '0;
          bd_vld  <= 1'b1;
          bd_byte <= shreg;
          bd_ferr <= ~maj;
          bd_perr <= perr_c;
        end
        default: st <= S_IDLE;
      endcase

      // idle timeout in bit-times; parks at TIMEOUT_BITS+1 so it fires once
      if (st == S_IDLE && fall)
        to_cnt <= '0;
      else if (to_fire)
        to_cnt <= TW'(TIMEOUT_BITS + 1);
      else if (st == S_IDLE && cnt == CLAST && to_cnt < TW'(TIMEOUT_BITS))
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // ---------------- packet assembler
  logic [1:0]               pst;
  logic [BYTE_SIZE-1:0]     opt_sh, len_sh;
  logic [OUT_DATA_SIZE-1:0] data_sh, data_wr;
  logic [IW-1:0]            idx;
  logic [BYTE_SIZE-1:0]     o_opt_q, o_len_q;
  logic [OUT_DATA_SIZE-1:0] o_data_q;
  logic                     o_valid_q, o_err_q;
  logic [1:0]               o_code_q;

  always_comb begin
    data_wr = data_sh;
    data_wr[idx*BYTE_SIZE +: BYTE_SIZE] = bd_byte;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pst       <= P_OPT;
      opt_sh    <= '0;
      len_sh    <= '0;
      data_sh   <= '0;
      idx       <= '0;
      o_opt_q   <= '0;
      o_len_q   <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_err_q   <= 1'b0;
      o_code_q  <= 2'd0;
    end else begin
      o_valid_q <= 1'b0;
      o_err_q   <= 1'b0;
      if (bd_vld && pst != P_DROP && (bd_ferr || bd_perr)) begin
        o_err_q  <= 1'b1;
        o_code_q <= bd_ferr ? 2'd1 : 2'd2;   // framing wins over parity
        pst      <= P_DROP;
      end else if (bd_vld) begin
        case (pst)
          P_OPT: begin
            opt_sh  <= bd_byte;
            data_sh <= '0;
            pst     <= P_LEN;
          end
          P_LEN: begin
            len_sh <= bd_byte;
            if (bd_byte == '0) begin
              o_opt_q   <= opt_sh;
              o_len_q   <= '0;
              o_data_q  <= data_sh;
              o_valid_q <= 1'b1;
              pst       <= P_OPT;
            end else if (bd_byte > BYTE_SIZE'(MAX_MSG_LEN)) begin
              o_err_q  <= 1'b1;
              o_code_q <= 2'd3;
              pst      <= P_DROP;
            end else begin
              idx <= '0;
              pst <= P_DATA;
            end
          end
          P_DATA: begin
            data_sh <= data_wr;
            if (BYTE_SIZE'(idx) == len_sh - 1'b1) begin
              o_opt_q   <= opt_sh;
              o_len_q   <= len_sh;
              o_data_q  <= data_wr;
              o_valid_q <= 1'b1;
              pst       <= P_OPT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: ;                       // P_DROP swallows bytes
        endcase
      end else if (to_fire) begin
        case (pst)
          P_LEN, P_DATA: begin
            o_err_q  <= 1'b1;
            o_code_q <= 2'd0;
            pst      <= P_OPT;
          end
          P_DROP:  pst <= P_OPT;
          default: ;
        endcase
      end
    end
  end

  assign bus.o_opt      = o_opt_q;
  assign bus.o_len      = o_len_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.o_err      = o_err_q;
  assign bus.o_err_code = o_code_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx
//   Directed bench for uart_frame_rx at default parameters. A negedge
//   monitor counts o_valid / o_err pulses and captures their payload;
//   each scenario compares deltas of those counts and captured values
//   against hand-computed expectations.
module tb_uart_frame_rx;
  localparam int F = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_rx_if #(.BYTE_SIZE(8), .OUT_DATA_SIZE(32)) bus ();

  uart_frame_rx #(
    .BYTE_SIZE(8), .FREQ_COEF(F), .MAX_MSG_LEN(4), .OUT_DATA_SIZE(32),
    .PARITY_ODD(0), .TIMEOUT_BITS(20)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0, n_err = 0, n_both = 0, valid_cyc = 0;
  logic [1:0] last_code = 2'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid) begin n_valid++; valid_cyc = cyc; end
      if (bus.o_err)   begin n_err++;   last_code = bus.o_err_code; end
      if (bus.o_valid && bus.o_err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int start_cyc = 0;

  // called at a negedge; one full character, F clocks per bit
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
    start_cyc  = cyc;
    bus.in_bit = 1'b0;
    repeat (F) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.in_bit = b[i];
      repeat (F) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.in_bit = (^b) ^ par_flip;
    repeat (F) @(negedge clk);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    bus.in_bit = stop_b;
    repeat (F) @(negedge clk);
    bus.in_bit = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
  endtask

  task automatic idle_bits(input int n);
    bus.in_bit = 1'b1;
    repeat (n * F) @(negedge clk);
  endtask

  int v0, e0;

  initial begin
    bus.in_bit = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_opt",   bus.o_opt, 0);
    chk("rst_len",   bus.o_len, 0);
    chk("rst_data",  bus.o_data, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_err",   bus.o_err, 0);
    chk("rst_code",  bus.o_err_code, 0);
    rst = 1'b0;
    idle_bits(1);

    // full packet, two payload bytes
    v0 = n_valid; e0 = n_err;
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    idle_bits(1);
    chk("p1_valid", n_valid - v0, 1);
    chk("p1_err",   n_err - e0, 0);
    chk("p1_opt",   bus.o_opt, 8'hA5);
    chk("p1_len",   bus.o_len, 8'h02);
    chk("p1_data",  bus.o_data, 32'h0000_2211);

    // zero-length packet; start edge seen 3 clocks after the fall, stop
    // decision at count 9 of bit 9 -> 153 clocks later, valid 2 after that
    v0 = n_valid;
    send(8'h3C); send(8'h00);
    idle_bits(1);
    chk("z_valid", n_valid - v0, 1);
    chk("z_lat",   valid_cyc - start_cyc, 158);
    chk("z_opt",   bus.o_opt, 8'h3C);
    chk("z_len",   bus.o_len, 8'h00);
    chk("z_data",  bus.o_data, 0);

    // 4-clock glitch, then a good packet
    v0 = n_valid; e0 = n_err;
    bus.in_bit = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(3);
    chk("g_novalid", n_valid - v0, 0);
    chk("g_noerr",   n_err - e0, 0);
    send(8'h5A); send(8'h01); send(8'hC3);
    idle_bits(1);
    chk("g_valid", n_valid - v0, 1);
    chk("g_opt",   bus.o_opt, 8'h5A);
    chk("g_data",  bus.o_data, 32'h0000_00C3);

    // over-length, drop, timeout resync
    v0 = n_valid; e0 = n_err;
    send(8'h01); send(8'h05);
    idle_bits(1);
    chk("l_err",  n_err - e0, 1);
    chk("l_code", last_code, 3);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    idle_bits(1);
    chk("l_drop_valid", n_valid - v0, 0);
    chk("l_drop_err",   n_err - e0, 1);
    idle_bits(22);
    chk("l_idle_err", n_err - e0, 1);
    send(8'h02); send(8'h01); send(8'h7E);
    idle_bits(1);
    chk("l_valid", n_valid - v0, 1);
    chk("l_opt",   bus.o_opt, 8'h02);
    chk("l_len",   bus.o_len, 8'h01);
    chk("l_data",  bus.o_data, 32'h0000_007E);

    // partial packet then idle -> single timeout error
    v0 = n_valid; e0 = n_err;
    send(8'h01); send(8'h03); send(8'h44);
    idle_bits(25);
    chk("t_err",   n_err - e0, 1);
    chk("t_code",  last_code, 0);
    chk("t_valid", n_valid - v0, 0);
    chk("t_opt",   bus.o_opt, 8'h02);
    chk("t_len",   bus.o_len, 8'h01);
    chk("t_data",  bus.o_data, 32'h0000_007E);

    // bad stop bit on the length byte
    e0 = n_err;
    send(8'h01); send_frame(8'h03, 1'b0, 1'b0);
    idle_bits(1);
    chk("f_err",  n_err - e0, 1);
    chk("f_code", last_code, 1);
    idle_bits(22);
    chk("f_idle_err", n_err - e0, 1);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit should be 1, send 0
    e0 = n_err;
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    chk("par_err",  n_err - e0, 1);
    chk("par_code", last_code, 2);
    idle_bits(22);
`endif

    // reset in the middle of a payload byte
    send(8'h01); send(8'h04); send(8'h11);
    bus.in_bit = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    bus.in_bit = 1'b1;
    #1;
    chk("r_opt",   bus.o_opt, 0);
    chk("r_len",   bus.o_len, 0);
    chk("r_data",  bus.o_data, 0);
    chk("r_valid", bus.o_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    v0 = n_valid; e0 = n_err;
    send(8'h09); send(8'h01); send(8'hAB);
    idle_bits(1);
    chk("r2_valid", n_valid - v0, 1);
    chk("r2_err",   n_err - e0, 0);
    chk("r2_opt",   bus.o_opt, 8'h09);
    chk("r2_data",  bus.o_data, 32'h0000_00AB);

    chk("excl", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Oversampled UART receiver with 3-sample majority voting, glitch-rejecting start detection, framing and optional parity checking, and an integrated packet assembler. It builds `opt`, `len` and up to `MAX_MSG_LEN` payload bytes into one flat output word. An inter-byte idle timeout resynchronises the packet layer after errors. The block sits directly on the serial pin and feeds the command decoder with one `o_valid` pulse per complete packet, or one `o_err` pulse per rejected packet.

## Interface
- `BYTE_SIZE`, 8, data bits per UART character.
- `FREQ_COEF`, 16, CLK cycles per bit; must be even and ≥ 6.
- `MAX_MSG_LEN`, 4, maximum payload bytes; must be ≤ 2^BYTE_SIZE − 1.
- `OUT_DATA_SIZE`, MAX_MSG_LEN*BYTE_SIZE, width of `o_data`.
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- `TIMEOUT_BITS`, 20, idle bit-times that abort a partial packet.
- `CLK` input 1: single clock.
- `RST` input 1: reset, asynchronous, active-high.
- `in_bit` input 1: serial line, idle high, asynchronous to CLK.
- `o_opt` output BYTE_SIZE: option byte of the last valid packet.
- `o_len` output BYTE_SIZE: length byte of the last valid packet.
- `o_data` output OUT_DATA_SIZE: payload; byte k at [k*BYTE_SIZE +: BYTE_SIZE]; unused bytes are 0.
- `o_valid` output 1: one-cycle pulse when a packet completes.
- `o_err` output 1: one-cycle pulse when a packet is rejected.
- `o_err_code` output 2: cause, valid with `o_err`: 0 timeout, 1 framing, 2 parity, 3 length.

## Operation
- Input path: 2-FF synchronizer, reset to 1. Falling-edge detect runs on the synchronized line.
- Byte FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - A bit counter (0..FREQ_COEF−1) restarts at 0 on start-edge detect and at each bit boundary.
  - Samples are taken at counts FREQ_COEF/2−1, FREQ_COEF/2 and FREQ_COEF/2+1. The bit value is the majority of the three.
- IDLE→START on falling edge.
- START: a majority of 1 means a glitch → IDLE with no error. A majority of 0 → DATA.
- DATA: BYTE_SIZE bits, LSB first, then → PARITY or STOP.
- STOP:
  - Decision at the third sample; the FSM returns to IDLE immediately (half-bit early) so it can resync on a back-to-back start.
  - Stop majority 0 → framing error.
  - Parity mismatch → parity error; framing takes priority when both occur.
- Byte-done strobe: registered, asserted one cycle after the stop decision, carrying the byte and its error flag.
- Packet FSM states: P_OPT, P_LEN, P_DATA, P_DROP.
  - P_OPT: store opt; clear the payload shadow to 0 → P_LEN.
  - P_LEN:
    - len = 0 → emit the packet, then → P_OPT.
    - len > MAX_MSG_LEN → `o_err` code 3, then → P_DROP.
    - Otherwise → P_DATA with payload index 0.
  - P_DATA: write the byte at the index and increment. When index reaches len−1 → emit the packet, then → P_OPT.
  - In any state, a byte with a framing or parity error → `o_err` with code 1 or 2, then → P_DROP.
  - P_DROP ignores all bytes.
- Timeout counter:
  - Counts bit-times while the byte FSM is IDLE.
  - Clears on every start edge.
  - Reaching TIMEOUT_BITS: P_LEN or P_DATA → `o_err` code 0, → P_OPT. P_DROP → P_OPT with no error. P_OPT → no action.
- Emit: `o_opt`, `o_len` and `o_data` load from the shadow registers and hold until the next emit. Error paths never change them.
- `o_valid` and `o_err` are mutually exclusive in any cycle.

## Timing
- Reset values: `o_opt`, `o_len`, `o_data` = 0. `o_valid` = `o_err` = 0. `o_err_code` = 0.
- Internal reset values: both FSMs idle (IDLE / P_OPT), all counters 0.
- Reset mid-frame discards all partial state. The first falling edge after reset release starts a new byte.
- Latency from the line falling edge to detect: 3 CLK (2 sync stages plus edge register).
- `o_valid` / `o_err`: asserted 2 CLK after the stop-bit decision cycle of the terminating byte, for exactly 1 cycle.
- Timeout `o_err`: 1 CLK after the counter reaches TIMEOUT_BITS.
- No backpressure. The consumer must sample outputs on `o_valid`. Outputs stay stable until the next `o_valid`.

## Configuration
- `UART_RX_PARITY_EN` defined: one parity bit follows the data bits, with sense set by PARITY_ODD. Error code 2 is reachable.
- `UART_RX_PARITY_EN` undefined: PARITY state and logic are absent. The frame is start + BYTE_SIZE data + stop. Code 2 never occurs. PARITY_ODD is ignored.

## Test plan
All scenarios use the defaults (FREQ_COEF=16, MAX_MSG_LEN=4).
- Bytes A5, 02, 11, 22 back-to-back → one `o_valid`; `o_opt`=A5, `o_len`=02, `o_data`=0x00002211; no `o_err`.
- Bytes 3C, 00 → `o_valid` 2 CLK after the second stop decision; `o_data`=0.
- 4-CLK low pulse on an idle line → no byte, no `o_err`, FSMs stay idle. Then a full valid packet is received correctly.
- Bytes 01, 05 → `o_err` code 3. The next 5 bytes produce nothing. After a 20-bit idle, packet 02, 01, 7E → `o_valid`, `o_data`=0x0000007E.
- Bytes 01, 03, 44, then idle → `o_err` code 0 exactly once. Outputs keep the previous packet's values. Variant: second byte with stop bit 0 → `o_err` code 1.
- With `UART_RX_PARITY_EN` and PARITY_ODD=0: byte 0x07 with parity bit 0 → `o_err` code 2. Variant: assert `RST` mid-payload → all outputs 0 immediately, and the next packet is received cleanly.
